eb_rd_ptr_sync_status: RTL
==========================

// Module: eb_rd_ptr_sync_status
// PURPOSE
//  Write-domain status unit for the elastic buffer. Brings LANES read-pointer gray counters into
//  read_to_write_clk through a SYNC_STAGES flop chain and converts them to binary. Computes per-lane
//  fill level against the local binary write pointer and registers full / almost_full.
//  Replaces the fixed 3-flop, single-lane pointer sync in the write path.
// PARAMETERS
//  ADDR_W        4   buffer address width; pointers are ADDR_W+1 bits; DEPTH = 2**ADDR_W
//  SYNC_STAGES   3   synchronizer flops per pointer bit; legal range 2..4
//  LANES         1   independent lanes, packed lane-major (lane 0 in LSBs)
//  AFULL_THRESH  12  almost_full asserts when fill >= AFULL_THRESH; legal range 1..DEPTH
// PORTS
//  read_to_write_clk  in   1                clock (write domain)
//  rst_n              in   1                asynchronous, active-low reset
//  gray_counter_read  in   LANES*(ADDR_W+1) read-domain gray pointers (asynchronous to clk)
//  wr_ptr_bin         in   LANES*(ADDR_W+1) local binary write pointers (clk domain)
//  err_clr            in   1                clears all sticky gray_err bits
//  rd_ptr_gray_sync   out  LANES*(ADDR_W+1) synchronized gray pointer (last sync flop)
//  rd_ptr_bin_sync    out  LANES*(ADDR_W+1) registered binary of rd_ptr_gray_sync
//  fill_level         out  LANES*(ADDR_W+1) registered (wr_ptr_bin - rd_ptr_bin) mod 2**(ADDR_W+1)
//  full               out  LANES            registered, fill == DEPTH
//  almost_full        out  LANES            registered, fill >= AFULL_THRESH
//  gray_err           out  LANES            sticky gray-code violation flag
// BEHAVIOUR
//  - Reset (async, any time, including mid-stream): all sync flops, outputs and error state go to 0.
//    No output glitches high on reset release.
//  - Sync latency: a stable gray_counter_read value appears on rd_ptr_gray_sync after exactly
//    SYNC_STAGES rising edges.
//  - Conversion: rd_ptr_bin_sync = gray2bin(rd_ptr_gray_sync), registered; +1 cycle, total SYNC_STAGES+1.
//  - Fill: fill_level, full and almost_full are registered from the current wr_ptr_bin and the
//    combinational gray2bin of rd_ptr_gray_sync. Latency is 1 cycle from wr_ptr_bin and
//    SYNC_STAGES+1 from the read pointer.
//  - Arithmetic: (ADDR_W+1)-bit unsigned subtract with natural wrap, so pointer wrap past
//    2**(ADDR_W+1)-1 is transparent. fill > DEPTH is not saturated; it is reported raw.
//  - Lanes are fully independent; there is no cross-lane logic except the shared err_clr.
//  - Only the first sync flop may sample gray_counter_read. No combinational logic before the
//    sync chain.
// CONFIGURATION
//  Macro EB_GRAY_CHECK_EN:
//  - Defined: per lane, register the previous rd_ptr_gray_sync. If popcount(prev ^ cur) > 1,
//    set gray_err[lane] the following cycle.
//    - gray_err is sticky until err_clr.
//    - When a new violation and err_clr occur in the same cycle, set wins.
//    - The first compare after reset uses prev = 0.
//  - Undefined: gray_err is tied to 0, no compare registers are built, and err_clr is ignored.
// STRUCTURE
//  - Package eb_sync_pkg: PTR_W = ADDR_W+1 helper, function gray2bin, function
//    onehot_or_zero (gray step check), typedef ptr_t.
//  - Sub-module eb_sync_chain (WIDTH, STAGES): plain async-reset flop chain, instantiated once
//    per lane. The generate loop over LANES lives in the top.
// TESTING (ADDR_W=4, SYNC_STAGES=3, AFULL_THRESH=12 unless noted)
//  1. Reset with inputs nonzero -> every output 0. Release reset -> outputs still 0 until a
//     synced value propagates.
//  2. gray_counter_read 0->5'b00001 at edge 0 -> rd_ptr_gray_sync=00001 after edge 3;
//     rd_ptr_bin_sync=1 after edge 4.
//  3. rd=0, wr_ptr_bin=16 -> fill_level=16, full=1, almost_full=1 one edge later;
//     wr_ptr_bin=11 -> fill=11, full=0, almost_full=0.
//  4. Wrap: rd gray 5'b10001 (bin 30), wr_ptr_bin=2 -> fill_level=4, full=0, almost_full=0.
//  5. EB_GRAY_CHECK_EN: gray 00000->00011 -> gray_err=1 and stays set.
//     err_clr pulse -> 0. Violation coincident with err_clr -> stays 1.
//     Macro undefined -> gray_err stays 0.
//  6. LANES=2, SYNC_STAGES=2: lane0 full while lane1 is empty -> flags independent;
//     latency is 2+1 cycles on both lanes.

Source files
------------

// File: rtl/eb_rd_ptr_sync_status_pkg.sv
// Shared types and helpers for the elastic-buffer read-pointer sync path.
// Pointers are carried zero-extended in ptr_t; callers keep the low PTR_W bits.
package eb_sync_pkg;
    localparam int MAX_PTR_W = 16;
    typedef logic [MAX_PTR_W-1:0] ptr_t;

    function automatic int ptr_w(input int addr_w);
        return addr_w + 1;
    endfunction

    // Zero-extended gray converts to zero-extended binary, so one width serves all callers.
    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
        for (int i = MAX_PTR_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic onehot_or_zero(input ptr_t x);
        return (x & (x - ptr_t'(1))) == '0;
    endfunction
endpackage

// File: rtl/eb_rd_ptr_sync_status_if.sv
// Status bus of the write-domain read-pointer sync unit; lanes packed lane-major.
interface eb_rd_ptr_sync_status_if import eb_sync_pkg::*; #(
    parameter int ADDR_W = 4,
    parameter int LANES  = 1
) ();
    localparam int PTR_W = ptr_w(ADDR_W);

    logic [LANES-1:0][PTR_W-1:0] gray_counter_read;
    logic [LANES-1:0][PTR_W-1:0] wr_ptr_bin;
    logic                        err_clr;
    logic [LANES-1:0][PTR_W-1:0] rd_ptr_gray_sync;
    logic [LANES-1:0][PTR_W-1:0] rd_ptr_bin_sync;
    logic [LANES-1:0][PTR_W-1:0] fill_level;
    logic [LANES-1:0]            full;
    logic [LANES-1:0]            almost_full;
    logic [LANES-1:0]            gray_err;

    modport master (
        output gray_counter_read, wr_ptr_bin, err_clr,
        input  rd_ptr_gray_sync, rd_ptr_bin_sync, fill_level, full, almost_full, gray_err
    );
    modport slave (
        input  gray_counter_read, wr_ptr_bin, err_clr,
        output rd_ptr_gray_sync, rd_ptr_bin_sync, fill_level, full, almost_full, gray_err
    );
endinterface

// File: rtl/eb_rd_ptr_sync_status_chain.sv
// Plain async-reset synchronizer chain; d is sampled only by the first flop.
module eb_sync_chain #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [STAGES-1:0][WIDTH-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr <= '0;
        else        sr <= {sr[STAGES-2:0], d};
    end

    assign q = sr[STAGES-1];
endmodule

// File: rtl/eb_rd_ptr_sync_status.sv
// Write-domain status unit: syncs LANES read gray pointers, derives fill/full/almost_full.
// Optional gray-step checker built when EB_GRAY_CHECK_EN is defined.
module eb_rd_ptr_sync_status import eb_sync_pkg::*; #(
    parameter int ADDR_W       = 4,
    parameter int SYNC_STAGES  = 3,
    parameter int LANES        = 1,
    parameter int AFULL_THRESH = 12
) (
    input  logic                         read_to_write_clk,
    input  logic                         rst_n,
    eb_rd_ptr_sync_status_if.slave       bus
);
    localparam int PTR_W = ptr_w(ADDR_W);
    localparam int DEPTH = 1 << ADDR_W;

    logic [LANES-1:0][PTR_W-1:0] gray_sync, bin_comb, fill_comb, bin_q, fill_q;
    logic [LANES-1:0]            full_comb, afull_comb, full_q, afull_q, err;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        ptr_t bin_ext_unused_hi;

        eb_sync_chain #(.WIDTH(PTR_W), .STAGES(SYNC_STAGES)) u_sync (
            .clk   (read_to_write_clk),
            .rst_n (rst_n),
            .d     (bus.gray_counter_read[l]),
            .q     (gray_sync[l])
        );

        assign bin_ext_unused_hi = gray2bin(ptr_t'(gray_sync[l]));
        assign bin_comb[l]       = bin_ext_unused_hi[PTR_W-1:0];
        // Natural PTR_W-bit wrap makes pointer rollover transparent; overfill is reported raw.
        assign fill_comb[l]      = bus.wr_ptr_bin[l] - bin_comb[l];
        assign full_comb[l]      = fill_comb[l] == PTR_W'(DEPTH);
        assign afull_comb[l]     = fill_comb[l] >= PTR_W'(AFULL_THRESH);
    end

    always_ff @(posedge read_to_write_clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q   <= '0;
            fill_q  <= '0;
            full_q  <= '0;
            afull_q <= '0;
        end else begin
            bin_q   <= bin_comb;
            fill_q  <= fill_comb;
            full_q  <= full_comb;
            afull_q <= afull_comb;
        end
    end

`ifdef EB_GRAY_CHECK_EN
    logic [LANES-1:0][PTR_W-1:0] prev_q;
    logic [LANES-1:0]            viol, err_q;

    for (genvar l = 0; l < LANES; l++) begin : g_chk
        assign viol[l] = !onehot_or_zero(ptr_t'(prev_q[l] ^ gray_sync[l]));
    end

    // A fresh violation outranks a simultaneous clear.
    always_ff @(posedge read_to_write_clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
            err_q  <= '0;
        end else begin
            prev_q <= gray_sync;
            err_q  <= viol | (err_q & ~{LANES{bus.err_clr}});
        end
    end

    assign err = err_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = bus.err_clr;
    assign err            = '0;
`endif

    assign bus.rd_ptr_gray_sync = gray_sync;
    assign bus.rd_ptr_bin_sync  = bin_q;
    assign bus.fill_level       = fill_q;
    assign bus.full             = full_q;
    assign bus.almost_full      = afull_q;
    assign bus.gray_err         = err;
endmodule
